// File: rtl/gpio_seq_ctrl_if.sv
// Register-port bundle for the GPIO sequencer: the host requester side and
// the single-cycle GPIO controller register port share one interface.
// The slave modport is the sequencer's view; master is the environment's.
interface gpio_seq_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  host_req;
  logic                  host_wr;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic [DATA_WIDTH-1:0] host_wdata;
  logic                  host_gnt;
  logic [DATA_WIDTH-1:0] host_rdata;
  logic                  host_rvalid;

  logic                  reg_wr;
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic [DATA_WIDTH-1:0] reg_wdata;
  logic [DATA_WIDTH-1:0] reg_rdata;

  modport slave (
    input  host_req, host_wr, host_addr, host_wdata, reg_rdata,
    output host_gnt, host_rdata, host_rvalid, reg_wr, reg_addr, reg_wdata
  );

  modport master (
    output host_req, host_wr, host_addr, host_wdata, reg_rdata,
    input  host_gnt, host_rdata, host_rvalid, reg_wr, reg_addr, reg_wdata
  );
endinterface

// File: rtl/gpio_seq_ctrl.sv
// GPIO register-port sequencer: replays a programmed table of
// (address, data, delay) steps onto the GPIO register port, and shares that
// port with a host requester. The sequencer always wins in its ISSUE cycle.
module gpio_seq_ctrl #(
  parameter  int ADDR_WIDTH = 8,
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 8,
  parameter  int DLY_WIDTH  = 16,
  localparam int IDXW       = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tbl_wr,
  input  logic [IDXW-1:0]       tbl_idx,
  input  logic [ADDR_WIDTH-1:0] tbl_addr,
  input  logic [DATA_WIDTH-1:0] tbl_data,
  input  logic [DLY_WIDTH-1:0]  tbl_dly,
  input  logic [IDXW-1:0]       last_idx,
  input  logic                  loop_en,
  input  logic                  start,
  input  logic                  stop,
  output logic                  busy,
  output logic                  done,
  output logic [IDXW-1:0]       cur_step,
  gpio_seq_ctrl_if.slave        bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                state, state_next;
  logic [IDXW-1:0]       step_q, step_next;
  logic [IDXW-1:0]       last_q, last_next;
  logic [DLY_WIDTH-1:0]  cnt_q, cnt_next;
  logic                  done_q, done_next;
  logic                  advance;
  logic                  host_gnt;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [DLY_WIDTH-1:0]  dly_mem  [DEPTH];

  // Step table; only writable while idle so a running sequence never changes under itself
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i] <= '0;
        data_mem[i] <= '0;
        dly_mem[i]  <= '0;
      end
    end else if (tbl_wr && state == IDLE) begin
      addr_mem[tbl_idx] <= tbl_addr;
      data_mem[tbl_idx] <= tbl_data;
      dly_mem[tbl_idx]  <= tbl_dly;
    end
  end

  // Sequencer state register with step index, captured last index, delay counter and done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      step_q <= '0;
      last_q <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      step_q <= step_next;
      last_q <= last_next;
      cnt_q  <= cnt_next;
      done_q <= done_next;
    end
  end

  // Next-state logic; advancing past a step is a transition taken from ISSUE or WAIT, and stop overrides everything
  always_comb begin
    state_next = state;
    step_next  = step_q;
    last_next  = last_q;
    cnt_next   = cnt_q;
    done_next  = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_next = ISSUE;
          step_next  = '0;
          last_next  = last_idx;
        end
      end
      ISSUE: begin
        if (dly_mem[step_q] == '0) begin
          advance = 1'b1;
        end else begin
          cnt_next   = dly_mem[step_q];
          state_next = WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt_q - DLY_WIDTH'(1);
        if (cnt_q == DLY_WIDTH'(1)) begin
          advance = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (advance) begin
      if (step_q != last_q) begin
        step_next  = step_q + IDXW'(1);
        state_next = ISSUE;
      end else if (loop_en) begin
        step_next  = '0;
        state_next = ISSUE;
      end else begin
        state_next = IDLE;
        done_next  = 1'b1;
      end
    end
    if (stop) begin
      state_next = IDLE;
      cnt_next   = '0;
      done_next  = 1'b0;
    end
  end

  assign host_gnt = bus.host_req && (state != ISSUE);

  // Register-port mux: sequencer step in ISSUE, else a granted host access, else a quiet bus
  always_comb begin
    bus.reg_wr    = 1'b0;
    bus.reg_addr  = '0;
    bus.reg_wdata = '0;
    if (state == ISSUE) begin
      bus.reg_wr    = 1'b1;
      bus.reg_addr  = addr_mem[step_q];
      bus.reg_wdata = data_mem[step_q];
    end else if (host_gnt) begin
      bus.reg_wr    = bus.host_wr;
      bus.reg_addr  = bus.host_addr;
      bus.reg_wdata = bus.host_wdata;
    end
  end

  // Host read return: capture the controller's combinational read data on a granted read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= host_gnt && !bus.host_wr;
      if (host_gnt && !bus.host_wr) begin
        rdata_q <= bus.reg_rdata;
      end
    end
  end

  assign bus.host_gnt    = host_gnt;
  assign bus.host_rvalid = rvalid_q;
  assign bus.host_rdata  = rdata_q;
  assign busy            = (state != IDLE);
  assign done            = done_q;
  assign cur_step        = step_q;

endmodule

// File: tb/tb_gpio_seq_ctrl.sv
// Directed self-checking bench for gpio_seq_ctrl: sequence timing, looping,
// stop, host arbitration and reads, busy-time table protection, async reset.
module tb_gpio_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        tbl_wr;
  logic [2:0]  tbl_idx;
  logic [7:0]  tbl_addr;
  logic [31:0] tbl_data;
  logic [15:0] tbl_dly;
  logic [2:0]  last_idx;
  logic        loop_en;
  logic        start;
  logic        stop;
  logic        busy;
  logic        done;
  logic [2:0]  cur_step;

  int checks   = 0;
  int failures = 0;

  gpio_seq_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

  gpio_seq_ctrl #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(8), .DLY_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .tbl_wr(tbl_wr), .tbl_idx(tbl_idx), .tbl_addr(tbl_addr),
    .tbl_data(tbl_data), .tbl_dly(tbl_dly),
    .last_idx(last_idx), .loop_en(loop_en),
    .start(start), .stop(stop),
    .busy(busy), .done(done), .cur_step(cur_step),
    .bus(bus)
  );

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  // Hard time limit so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Moves to the next cycle, drives that cycle's inputs, then lets outputs settle
  task automatic applyStimulus(input logic s_start, input logic s_stop, input logic s_req,
                               input logic s_wr, input logic [7:0] s_addr, input logic [31:0] s_wdata);
    @(posedge clk);
    #1;
    start          = s_start;
    stop           = s_stop;
    bus.host_req   = s_req;
    bus.host_wr    = s_wr;
    bus.host_addr  = s_addr;
    bus.host_wdata = s_wdata;
    #2;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
  endtask

  task automatic tblWrite(input logic [2:0] idx, input logic [7:0] addr,
                          input logic [31:0] data, input logic [15:0] dly);
    @(posedge clk);
    #1;
    tbl_wr   = 1'b1;
    tbl_idx  = idx;
    tbl_addr = addr;
    tbl_data = data;
    tbl_dly  = dly;
    @(posedge clk);
    #1;
    tbl_wr = 1'b0;
  endtask

  initial begin
    logic exp_wr;
    int   n;
    rst = 1'b1; tbl_wr = 1'b0; tbl_idx = '0; tbl_addr = '0; tbl_data = '0; tbl_dly = '0;
    last_idx = '0; loop_en = 1'b0; start = 1'b0; stop = 1'b0;
    bus.host_req = 1'b0; bus.host_wr = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
    bus.reg_rdata = '0;
    #7;
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_cur_step", cur_step, 3'd0);
    checkOutput("rst_reg_wr", bus.reg_wr, 1'b0);
    checkOutput("rst_reg_addr", bus.reg_addr, 8'h00);
    checkOutput("rst_reg_wdata", bus.reg_wdata, 32'h0);
    checkOutput("rst_rvalid", bus.host_rvalid, 1'b0);
    checkOutput("rst_rdata", bus.host_rdata, 32'h0);
    #5;
    rst = 1'b0;

    // Three-step sequence, no loop: writes at s+1, s+4, s+5; done at s+11
    $display("[TB] basic sequence");
    last_idx = 3'd2;
    tblWrite(3'd0, 8'h1C, 32'h1, 16'd2);
    tblWrite(3'd1, 8'h20, 32'h1, 16'd0);
    tblWrite(3'd2, 8'h24, 32'h3, 16'd5);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    checkOutput("t1_busy_s0", busy, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      idleCycle();
      exp_wr = (k == 1 || k == 4 || k == 5);
      checkOutput($sformatf("t1_wr_c%0d", k), bus.reg_wr, exp_wr);
      checkOutput($sformatf("t1_busy_c%0d", k), busy, (k <= 10));
      checkOutput($sformatf("t1_done_c%0d", k), done, (k == 11));
      if (k == 1) begin
        checkOutput("t1_addr_c1", bus.reg_addr, 8'h1C);
        checkOutput("t1_data_c1", bus.reg_wdata, 32'h1);
        checkOutput("t1_step_c1", cur_step, 3'd0);
      end
      if (k == 4) begin
        checkOutput("t1_addr_c4", bus.reg_addr, 8'h20);
        checkOutput("t1_data_c4", bus.reg_wdata, 32'h1);
        checkOutput("t1_step_c4", cur_step, 3'd1);
      end
      if (k == 5) begin
        checkOutput("t1_addr_c5", bus.reg_addr, 8'h24);
        checkOutput("t1_data_c5", bus.reg_wdata, 32'h3);
        checkOutput("t1_step_c5", cur_step, 3'd2);
      end
    end

    // Looping run wraps to step 0 at s+11, stop in s+12 ends it without done
    $display("[TB] loop and stop");
    loop_en = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    for (int k = 1; k <= 20; k++) begin
      if (k == 12) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
      else         idleCycle();
      exp_wr = (k == 1 || k == 4 || k == 5 || k == 11);
      checkOutput($sformatf("t2_wr_c%0d", k), bus.reg_wr, exp_wr);
      checkOutput($sformatf("t2_busy_c%0d", k), busy, (k <= 12));
      checkOutput($sformatf("t2_done_c%0d", k), done, 1'b0);
      if (k == 10) checkOutput("t2_step_c10", cur_step, 3'd2);
      if (k == 11) begin
        checkOutput("t2_step_c11", cur_step, 3'd0);
        checkOutput("t2_addr_c11", bus.reg_addr, 8'h1C);
      end
    end
    loop_en = 1'b0;

    // Idle host read, then idle host write
    $display("[TB] host access while idle");
    bus.reg_rdata = 32'hA5;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 32'h0);
    checkOutput("t3_gnt", bus.host_gnt, 1'b1);
    checkOutput("t3_addr", bus.reg_addr, 8'h00);
    checkOutput("t3_wr", bus.reg_wr, 1'b0);
    idleCycle();
    checkOutput("t3_rvalid", bus.host_rvalid, 1'b1);
    checkOutput("t3_rdata", bus.host_rdata, 32'hA5);
    idleCycle();
    checkOutput("t3_rvalid_off", bus.host_rvalid, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h08, 32'h55);
    checkOutput("t3_wgnt", bus.host_gnt, 1'b1);
    checkOutput("t3_wwr", bus.reg_wr, 1'b1);
    checkOutput("t3_waddr", bus.reg_addr, 8'h08);
    checkOutput("t3_wdata", bus.reg_wdata, 32'h55);
    idleCycle();
    checkOutput("t3_w_norvalid", bus.host_rvalid, 1'b0);

    // Host write stalled by a sequencer ISSUE cycle, granted on the next cycle
    $display("[TB] host write against sequencer");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h04, 32'hFF);
    checkOutput("t4_gnt_issue", bus.host_gnt, 1'b0);
    checkOutput("t4_wr_issue", bus.reg_wr, 1'b1);
    checkOutput("t4_addr_issue", bus.reg_addr, 8'h1C);
    checkOutput("t4_data_issue", bus.reg_wdata, 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h04, 32'hFF);
    checkOutput("t4_gnt_next", bus.host_gnt, 1'b1);
    checkOutput("t4_wr_next", bus.reg_wr, 1'b1);
    checkOutput("t4_addr_next", bus.reg_addr, 8'h04);
    checkOutput("t4_data_next", bus.reg_wdata, 32'hFF);
    idleCycle();
    checkOutput("t4_norvalid", bus.host_rvalid, 1'b0);
    n = 0;
    while (busy && n < 30) begin
      idleCycle();
      n++;
    end
    checkOutput("t4_drain", busy, 1'b0);

    // Eight zero-delay steps back to back; table write and start mid-run are ignored
    $display("[TB] back-to-back run");
    for (int i = 0; i < 8; i++) tblWrite(3'(i), 8'(8'h40 + 4 * i), 32'h100 + i, 16'd0);
    last_idx = 3'd7;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    for (int k = 1; k <= 10; k++) begin
      if (k == 5) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
      else        idleCycle();
      if (k == 4) tbl_wr = 1'b0;
      if (k == 6) last_idx = 3'd7;
      checkOutput($sformatf("t5_wr_c%0d", k), bus.reg_wr, (k <= 8));
      checkOutput($sformatf("t5_busy_c%0d", k), busy, (k <= 8));
      checkOutput($sformatf("t5_done_c%0d", k), done, (k == 9));
      if (k <= 8) begin
        checkOutput($sformatf("t5_addr_c%0d", k), bus.reg_addr, 32'h40 + 4 * (k - 1));
        checkOutput($sformatf("t5_data_c%0d", k), bus.reg_wdata, 32'h100 + (k - 1));
        checkOutput($sformatf("t5_step_c%0d", k), cur_step, k - 1);
      end
      if (k == 3) begin
        tbl_wr = 1'b1; tbl_idx = 3'd3; tbl_addr = 8'hEE; tbl_data = 32'hDEAD; tbl_dly = 16'd0;
        last_idx = 3'd3;
      end
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    for (int k = 1; k <= 9; k++) begin
      idleCycle();
      checkOutput($sformatf("t5b_wr_c%0d", k), bus.reg_wr, (k <= 8));
      checkOutput($sformatf("t5b_done_c%0d", k), done, (k == 9));
      if (k <= 8) begin
        checkOutput($sformatf("t5b_addr_c%0d", k), bus.reg_addr, 32'h40 + 4 * (k - 1));
        checkOutput($sformatf("t5b_data_c%0d", k), bus.reg_wdata, 32'h100 + (k - 1));
      end
    end

    // Asynchronous reset during WAIT clears everything including the table
    $display("[TB] reset during wait");
    tblWrite(3'd0, 8'h40, 32'h100, 16'd5);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    idleCycle();
    checkOutput("t6_wr_issue", bus.reg_wr, 1'b1);
    idleCycle();
    checkOutput("t6_busy_wait", busy, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("t6_busy", busy, 1'b0);
    checkOutput("t6_done", done, 1'b0);
    checkOutput("t6_step", cur_step, 3'd0);
    checkOutput("t6_reg_wr", bus.reg_wr, 1'b0);
    checkOutput("t6_reg_addr", bus.reg_addr, 8'h00);
    checkOutput("t6_reg_wdata", bus.reg_wdata, 32'h0);
    checkOutput("t6_rvalid", bus.host_rvalid, 1'b0);
    checkOutput("t6_rdata", bus.host_rdata, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      idleCycle();
      checkOutput($sformatf("t6_post_wr_c%0d", k), bus.reg_wr, 1'b0);
      checkOutput($sformatf("t6_post_busy_c%0d", k), busy, 1'b0);
    end
    last_idx = 3'd0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    idleCycle();
    checkOutput("t6_tbl_wr", bus.reg_wr, 1'b1);
    checkOutput("t6_tbl_addr", bus.reg_addr, 8'h00);
    checkOutput("t6_tbl_data", bus.reg_wdata, 32'h0);
    idleCycle();
    checkOutput("t6_tbl_done", done, 1'b1);
    checkOutput("t6_tbl_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
